grf: RTL and testbench
======================

// Module: grf
// PURPOSE
//  General register file for the 5-stage MIPS pipeline; receiving end of the writeback path.
//  Holds 32 x 32-bit GPRs and accepts the write-back result (reg index, data, PC) from WB.
//  Serves two combinational read ports to decode (rs/rt).
//  Optional write-to-read bypass lets the same-cycle WB result reach decode.
//  Emits a simulation-only write trace for result comparison.
// PARAMETERS
//  WIDTH   32  data width of each register
//  BYPASS  1   1: a read port returns same-cycle write data on an address match; 0: returns the stored value
//  TRACE   1   1: $display one line per committed write (sim only, no synthesis effect)
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      synchronous, active-high; clears all registers
//  we       in   1      write enable from WB (regWrite of the WB-stage instruction)
//  wa       in   5      write address (regWA_4)
//  wd       in   WIDTH  write data (toRegout_4)
//  pc_4     in   32     PC of the WB-stage instruction, used only by the trace
//  ra1      in   5      read address 1 (rs)
//  ra2      in   5      read address 2 (rt)
//  rd1      out  WIDTH  read data 1
//  rd2      out  WIDTH  read data 2
// BEHAVIOUR
//  - Storage: regs[1..31] are flops. $0 is not stored; every read of address 0 returns 0.
//  - Reset: at a posedge with reset=1, regs[1..31] <= 0.
//    - Reset overrides any write in the same cycle; no trace line is printed.
//    - Mid-operation reset discards the in-flight write.
//  - Write: at a posedge with reset=0, we=1 and wa!=0, regs[wa] <= wd.
//    - A write with wa=0 is dropped and produces no trace.
//    - A write with we=0 never changes state.
//  - Read: rd1/rd2 are purely combinational from ra1/ra2 and state. Read latency is 0 cycles.
//  - Write-to-read latency:
//    - BYPASS=1: rdN = wd when (we && !reset && wa!=0 && wa==raN); otherwise rdN = regs[raN].
//      Effective 0 cycles.
//    - BYPASS=0: the new value is visible the cycle after the write edge.
//  - Both ports may address the same register, and either port may match wa. Each port resolves independently.
//  - Output values after reset: rd1 = rd2 = 0 for every address until the first write.
//    With BYPASS=1, the bypass is suppressed while reset=1.
//  - Trace (TRACE=1): on each committed write, print "@%h: $%d <= %h" with pc_4, wa, wd.
//    Exactly one line per committed write, printed at the clock edge.
//  - X-safety: with we=0, X on wa/wd must not corrupt state or the outputs.
// TESTING
//  1. Reset, then read all 32 addresses on both ports -> every rd1/rd2 = 32'h0.
//  2. we=1, wa=5, wd=32'hDEADBEEF, pc_4=32'h3000 -> next cycle ra1=5 gives DEADBEEF.
//     Exactly one trace "@00003000: $ 5 <= deadbeef".
//  3. we=1, wa=0, wd=32'h1234 -> ra1=0 still gives 0; no trace line.
//  4. BYPASS=1: ra1=ra2=wa=8, we=1, wd=32'h55 in the same cycle -> rd1=rd2=32'h55 before the edge.
//     With BYPASS=0, both show the old value until after the edge.
//  5. Write wa=3, wd=32'h7 together with reset=1 -> regs[3]=0 afterwards; no trace.
//     Next write wa=3, wd=32'h9 -> reads 9.
//  6. Back-to-back writes to wa=31 (32'hA then 32'hB) while ra2=31 -> rd2 reads A, then B, cycle by cycle.
//     Exactly two trace lines in order.

Source files
------------

// File: rtl/grf_if.sv
// rtl/grf_if.sv - write-back and decode read bundle for the general register file
interface grf_if #(
    parameter int WIDTH = 32
);
    logic             we;
    logic [4:0]       wa;
    logic [WIDTH-1:0] wd;
    logic [31:0]      pc_4;
    logic [4:0]       ra1;
    logic [4:0]       ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    modport master (
        output we, wa, wd, pc_4, ra1, ra2,
        input  rd1, rd2
    );

    modport slave (
        input  we, wa, wd, pc_4, ra1, ra2,
        output rd1, rd2
    );
endinterface

// File: rtl/grf.sv
// rtl/grf.sv - 32 x WIDTH general register file, two combinational read ports, optional bypass
module grf #(
    parameter int WIDTH  = 32,
    parameter int BYPASS = 1,
    parameter int TRACE  = 1
) (
    input  logic  clk,
    input  logic  reset,
    grf_if.slave  bus
);

    // $0 has no storage; index 0 of the read view is tied to zero
    logic [WIDTH-1:0] r_regs [1:31];
    logic [WIDTH-1:0] w_rf   [0:31];
    logic             w_commit;
    logic             w_hit1;
    logic             w_hit2;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    // a write commits only when enabled, not in reset and not aimed at $0
    assign w_commit = bus.we && !reset && (bus.wa != 5'd0);
    assign w_hit1   = w_commit && (bus.wa == bus.ra1);
    assign w_hit2   = w_commit && (bus.wa == bus.ra2);

    // register storage: reset wins over any same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[bus.wa] <= bus.wd;
        end
    end

    // flat read view with the hard-wired zero register
    always_comb begin
        w_rf[0] = '0;
        for (int i = 1; i < 32; i++) begin
            w_rf[i] = r_regs[i];
        end
    end

    // read port 1: stored value, or same-cycle write data when bypass is enabled
    always_comb begin
        w_rd1 = w_rf[bus.ra1];
        if ((BYPASS != 0) && w_hit1) begin
            w_rd1 = bus.wd;
        end
    end

    // read port 2: resolved independently of port 1
    always_comb begin
        w_rd2 = w_rf[bus.ra2];
        if ((BYPASS != 0) && w_hit2) begin
            w_rd2 = bus.wd;
        end
    end

    assign bus.rd1 = w_rd1;
    assign bus.rd2 = w_rd2;

`ifndef SYNTHESIS
    // commit trace: one line per write that actually lands in the file
    always_ff @(posedge clk) begin
        if ((TRACE != 0) && w_commit) begin
            $display("@%h: $%d <= %h", bus.pc_4, bus.wa, bus.wd);
        end
    end
`endif

endmodule

// File: tb/tb_grf.sv
// tb/tb_grf.sv - scoreboard bench for grf, bypass and non-bypass instances side by side
module tb_grf;

    logic clk;
    logic reset;

    grf_if #(.WIDTH(32)) if_b ();
    grf_if #(.WIDTH(32)) if_n ();

    grf #(.WIDTH(32), .BYPASS(1), .TRACE(1)) u_grf_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    grf #(.WIDTH(32), .BYPASS(0), .TRACE(0)) u_grf_n (
        .clk   (clk),
        .reset (reset),
        .bus   (if_n.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [32];
    int          n_chk;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic byp, input logic rst, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd,
                                             input logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        if (byp && we === 1'b1 && !rst && wa != 5'd0 && wa == ra) return wd;
        return m_regs[ra];
    endfunction

    // one clock cycle: drive after the edge, predict, compare mid-cycle, then advance the model
    task automatic step(input string tag, input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [31:0] pc,
                        input logic [4:0] ra1, input logic [4:0] ra2);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        if_b.we   = we;   if_n.we   = we;
        if_b.wa   = wa;   if_n.wa   = wa;
        if_b.wd   = wd;   if_n.wd   = wd;
        if_b.pc_4 = pc;   if_n.pc_4 = pc;
        if_b.ra1  = ra1;  if_n.ra1  = ra1;
        if_b.ra2  = ra2;  if_n.ra2  = ra2;
        e.tag = {tag, "/byp_rd1"}; e.exp = model_rd(1'b1, rst, we, wa, wd, ra1); sb_q.push_back(e);
        e.tag = {tag, "/byp_rd2"}; e.exp = model_rd(1'b1, rst, we, wa, wd, ra2); sb_q.push_back(e);
        e.tag = {tag, "/nob_rd1"}; e.exp = model_rd(1'b0, rst, we, wa, wd, ra1); sb_q.push_back(e);
        e.tag = {tag, "/nob_rd2"}; e.exp = model_rd(1'b0, rst, we, wa, wd, ra2); sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front(); check_val(e.tag, if_b.rd1, e.exp);
        e = sb_q.pop_front(); check_val(e.tag, if_b.rd2, e.exp);
        e = sb_q.pop_front(); check_val(e.tag, if_n.rd1, e.exp);
        e = sb_q.pop_front(); check_val(e.tag, if_n.rd2, e.exp);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else if (we === 1'b1 && wa != 5'd0) begin
            m_regs[wa] = wd;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        reset = 1'b1;
        if_b.we = 1'b0; if_n.we = 1'b0;
        if_b.wa = '0;   if_n.wa = '0;
        if_b.wd = '0;   if_n.wd = '0;
        if_b.pc_4 = '0; if_n.pc_4 = '0;
        if_b.ra1 = '0;  if_n.ra1 = '0;
        if_b.ra2 = '0;  if_n.ra2 = '0;

        step("rst0", 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        step("rst1", 1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd2);

        // every address on both ports reads zero after reset
        for (int i = 0; i < 32; i++) begin
            step($sformatf("rdall%0d", i), 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
        end

        // plain write then read
        step("wr5",    1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h3000, 5'd1, 5'd2);
        step("rd5",    1'b0, 1'b0, 5'd0, 32'h0,        32'h0,    5'd5, 5'd5);

        // write to $0 is dropped
        step("wr0",    1'b0, 1'b1, 5'd0, 32'h1234,     32'h3004, 5'd0, 5'd0);
        step("rd0",    1'b0, 1'b0, 5'd0, 32'h0,        32'h0,    5'd0, 5'd5);

        // same-cycle bypass on both ports, non-bypass instance shows old value
        step("byp8",   1'b0, 1'b1, 5'd8, 32'h55,       32'h3008, 5'd8, 5'd8);
        step("rd8",    1'b0, 1'b0, 5'd0, 32'h0,        32'h0,    5'd8, 5'd8);

        // one port matching the write address, the other not
        step("byp_mx", 1'b0, 1'b1, 5'd9, 32'h99,       32'h300C, 5'd9, 5'd8);

        // reset overrides a same-cycle write and suppresses the bypass
        step("wr3r",   1'b0, 1'b1, 5'd3, 32'h6,        32'h3010, 5'd3, 5'd5);
        step("rst_wr", 1'b1, 1'b1, 5'd3, 32'h7,        32'h3014, 5'd3, 5'd5);
        step("rd3r",   1'b0, 1'b0, 5'd0, 32'h0,        32'h0,    5'd3, 5'd5);
        step("wr3",    1'b0, 1'b1, 5'd3, 32'h9,        32'h3018, 5'd3, 5'd0);
        step("rd3",    1'b0, 1'b0, 5'd0, 32'h0,        32'h0,    5'd3, 5'd3);

        // back-to-back writes to $31 observed on rd2
        step("w31a",   1'b0, 1'b1, 5'd31, 32'hA,       32'h301C, 5'd0, 5'd31);
        step("w31b",   1'b0, 1'b1, 5'd31, 32'hB,       32'h3020, 5'd0, 5'd31);
        step("r31",    1'b0, 1'b0, 5'd0,  32'h0,       32'h0,    5'd0, 5'd31);

        // unknown address/data with we=0 leaves state and outputs intact
        step("xwr",    1'b0, 1'b0, 5'bxxxxx, 32'hxxxxxxxx, 32'h0, 5'd3, 5'd31);
        step("xrd",    1'b0, 1'b0, 5'd0, 32'h0,        32'h0,    5'd3, 5'd31);

        // randomised write/read mix
        for (int k = 0; k < 40; k++) begin
            step($sformatf("rnd%0d", k), 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 32'($urandom), 32'h4000 + 32'(k * 4),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
